// File: rtl/pc_gen_unit_pkg.sv
// Shared definitions for the fetch-PC generator: redirect ranking and reset vector.
package pc_gen_unit_pkg;

  // Redirect source, ordered so that a numerically larger value has higher priority.
  typedef enum logic [1:0] {
    RK_SEQ = 2'd0,
    RK_D   = 2'd1,
    RK_E   = 2'd2,
    RK_M   = 2'd3
  } redirect_rank_e;

  // MIPS boot vector (kseg1 ROM).
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;

endpackage

// File: rtl/pc_lane_prio_sel.sv
// Lowest-index priority select across lanes: picks the 32-bit word of the oldest
// requesting lane and flags whether any lane requested at all.
module pc_lane_prio_sel #(
  parameter int LANES = 2
) (
  input  logic [LANES-1:0]    req,
  input  logic [32*LANES-1:0] data,
  output logic                valid,
  output logic [31:0]         sel
);

  logic [LANES-1:0] onehot;
  logic [31:0]      masked [LANES];

  // Isolate the lowest set request bit.
  assign onehot = req & ~(req - LANES'(1));
  assign valid  = |req;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_mask
      assign masked[gi] = onehot[gi] ? data[32*gi +: 32] : 32'd0;
    end
  endgenerate

  // OR-combine the masked words; at most one is non-zero.
  always_comb begin
    sel = 32'd0;
    for (int i = 0; i < LANES; i++) begin
      sel = sel | masked[i];
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-PC generator: ranks M trap / E mispredict / D jump redirects, holds a
// redirect that arrives while IF is stalled, and tags every redirect with an epoch.
module pc_gen_unit
  import pc_gen_unit_pkg::*;
#(
  parameter int          LANES    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          EPOCH_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallF,
  input  logic [LANES-1:0]    trap_M,
  input  logic [32*LANES-1:0] pc_exc_M,
  input  logic [LANES-1:0]    pred_take_E,
  input  logic [LANES-1:0]    actual_take_E,
  input  logic [32*LANES-1:0] pc_branch_E,
  input  logic [32*LANES-1:0] pc_plus8_E,
  input  logic [LANES-1:0]    jump_D,
  input  logic [32*LANES-1:0] pc_jump_D,
  input  logic [LANES-1:0]    pred_take_D,
  input  logic [32*LANES-1:0] pc_branch_D,
  output logic [31:0]         pc,
  output logic                redirect,
  output logic [1:0]          redirect_src,
  output logic                pending,
  output logic [EPOCH_W-1:0]  epoch
);

  localparam logic [31:0] SEQ_STEP = 32'(4 * LANES);

  logic [LANES-1:0]    e_req, d_req;
  logic [32*LANES-1:0] e_data, d_data;
  logic                m_valid, e_valid, d_valid;
  logic [31:0]         m_sel, e_sel, d_sel;

  redirect_rank_e new_rank;
  logic [31:0]    new_target;

  logic [31:0]        pc_reg, pc_next;
  redirect_rank_e     src_reg, src_next;
  logic               redirect_reg, redirect_next;
  logic               pend_reg, pend_next;
  redirect_rank_e     pend_rank_reg, pend_rank_next;
  logic [31:0]        pend_target_reg, pend_target_next;
  logic [EPOCH_W-1:0] epoch_reg, epoch_next;

  // Per-lane request and target formation for E and D.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign e_req[gi]              = pred_take_E[gi] ^ actual_take_E[gi];
      assign e_data[32*gi +: 32]    = actual_take_E[gi] ? pc_branch_E[32*gi +: 32]
                                                        : pc_plus8_E[32*gi +: 32];
      assign d_req[gi]              = jump_D[gi] | pred_take_D[gi];
      assign d_data[32*gi +: 32]    = jump_D[gi] ? pc_jump_D[32*gi +: 32]
                                                 : pc_branch_D[32*gi +: 32];
    end
  endgenerate

  pc_lane_prio_sel #(.LANES(LANES)) u_sel_m (
    .req(trap_M), .data(pc_exc_M), .valid(m_valid), .sel(m_sel)
  );
  pc_lane_prio_sel #(.LANES(LANES)) u_sel_e (
    .req(e_req), .data(e_data), .valid(e_valid), .sel(e_sel)
  );
  pc_lane_prio_sel #(.LANES(LANES)) u_sel_d (
    .req(d_req), .data(d_data), .valid(d_valid), .sel(d_sel)
  );

  // Cross-stage rank: an older stage flushes anything younger, so D only counts alone.
  always_comb begin
    new_rank   = RK_SEQ;
    new_target = 32'd0;
    if (m_valid) begin
      new_rank   = RK_M;
      new_target = m_sel;
    end else if (e_valid) begin
      new_rank   = RK_E;
      new_target = e_sel;
    end else if (d_valid) begin
      new_rank   = RK_D;
      new_target = d_sel;
    end
  end

  // Next-state: capture into the pending slot while stalled, apply on release.
  always_comb begin
    pc_next          = pc_reg;
    src_next         = src_reg;
    redirect_next    = 1'b0;
    pend_next        = pend_reg;
    pend_rank_next   = pend_rank_reg;
    pend_target_next = pend_target_reg;
    epoch_next       = epoch_reg;
    if (stallF) begin
      // >= lets a younger request of the same stage replace an older one.
      if (new_rank != RK_SEQ && new_rank >= pend_rank_reg) begin
        pend_next        = 1'b1;
        pend_rank_next   = new_rank;
        pend_target_next = new_target;
      end
    end else if (pend_reg) begin
      if (new_rank > pend_rank_reg) begin
        pc_next  = new_target;
        src_next = new_rank;
      end else begin
        pc_next  = pend_target_reg;
        src_next = pend_rank_reg;
      end
      redirect_next  = 1'b1;
      epoch_next     = epoch_reg + EPOCH_W'(1);
      pend_next      = 1'b0;
      pend_rank_next = RK_SEQ;
    end else if (new_rank != RK_SEQ) begin
      pc_next       = new_target;
      src_next      = new_rank;
      redirect_next = 1'b1;
      epoch_next    = epoch_reg + EPOCH_W'(1);
    end else begin
      pc_next  = pc_reg + SEQ_STEP;
      src_next = RK_SEQ;
    end
  end

  // State registers; reset also discards any held redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg          <= RESET_PC;
      src_reg         <= RK_SEQ;
      redirect_reg    <= 1'b0;
      pend_reg        <= 1'b0;
      pend_rank_reg   <= RK_SEQ;
      pend_target_reg <= 32'd0;
      epoch_reg       <= '0;
    end else begin
      pc_reg          <= pc_next;
      src_reg         <= src_next;
      redirect_reg    <= redirect_next;
      pend_reg        <= pend_next;
      pend_rank_reg   <= pend_rank_next;
      pend_target_reg <= pend_target_next;
      epoch_reg       <= epoch_next;
    end
  end

  assign pc           = pc_reg;
  assign redirect     = redirect_reg;
  assign redirect_src = src_reg;
  assign pending      = pend_reg;
  assign epoch        = epoch_reg;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: a reference model pushes the expected state
// per driven cycle, and it is popped and compared just after the clock edge.
module tb_pc_gen_unit;

  localparam logic [31:0] RPC = 32'hbfc0_0000;

  logic        clk, rst, rst1;
  logic        stallF;
  logic [1:0]  trap_M, pred_take_E, actual_take_E, jump_D, pred_take_D;
  logic [63:0] pc_exc_M, pc_branch_E, pc_plus8_E, pc_jump_D, pc_branch_D;
  logic [31:0] pc;
  logic        redirect, pending;
  logic [1:0]  redirect_src;
  logic [2:0]  epoch;

  // Single-lane instance, idle inputs: checks the 4-byte sequential step.
  logic        z1;
  logic [31:0] z32;
  logic [31:0] pc1;
  logic        redirect1, pending1;
  logic [1:0]  src1;
  logic [2:0]  epoch1;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  src;
    logic        red;
    logic        pend;
    logic [2:0]  epoch;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state.
  logic [31:0] m_pc, m_ptgt;
  int          m_src, m_prank, m_epoch;
  logic        m_red, m_pend;

  pc_gen_unit #(.LANES(2), .RESET_PC(RPC), .EPOCH_W(3)) u_dut (
    .clk(clk), .rst(rst), .stallF(stallF),
    .trap_M(trap_M), .pc_exc_M(pc_exc_M),
    .pred_take_E(pred_take_E), .actual_take_E(actual_take_E),
    .pc_branch_E(pc_branch_E), .pc_plus8_E(pc_plus8_E),
    .jump_D(jump_D), .pc_jump_D(pc_jump_D),
    .pred_take_D(pred_take_D), .pc_branch_D(pc_branch_D),
    .pc(pc), .redirect(redirect), .redirect_src(redirect_src),
    .pending(pending), .epoch(epoch)
  );

  pc_gen_unit #(.LANES(1), .RESET_PC(RPC), .EPOCH_W(3)) u_dut1 (
    .clk(clk), .rst(rst1), .stallF(z1),
    .trap_M(z1), .pc_exc_M(z32),
    .pred_take_E(z1), .actual_take_E(z1),
    .pc_branch_E(z32), .pc_plus8_E(z32),
    .jump_D(z1), .pc_jump_D(z32),
    .pred_take_D(z1), .pc_branch_D(z32),
    .pc(pc1), .redirect(redirect1), .redirect_src(src1),
    .pending(pending1), .epoch(epoch1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    stallF = 0; trap_M = 0; pred_take_E = 0; actual_take_E = 0;
    jump_D = 0; pred_take_D = 0;
    pc_exc_M = 0; pc_branch_E = 0; pc_plus8_E = 0; pc_jump_D = 0; pc_branch_D = 0;
  endtask

  task automatic model_reset();
    m_pc = RPC; m_src = 0; m_red = 0; m_pend = 0; m_prank = 0; m_ptgt = 0; m_epoch = 0;
  endtask

  // Evaluate the model for the currently driven inputs, push, clock, pop and compare.
  task automatic step();
    int nr;
    logic [31:0] nt;
    exp_t e, g;
    nr = 0; nt = 0;
    for (int i = 0; i < 2; i++)
      if (nr == 0 && trap_M[i]) begin nr = 3; nt = pc_exc_M[32*i +: 32]; end
    for (int i = 0; i < 2; i++)
      if (nr == 0 && (pred_take_E[i] != actual_take_E[i])) begin
        nr = 2; nt = actual_take_E[i] ? pc_branch_E[32*i +: 32] : pc_plus8_E[32*i +: 32];
      end
    for (int i = 0; i < 2; i++)
      if (nr == 0 && (jump_D[i] || pred_take_D[i])) begin
        nr = 1; nt = jump_D[i] ? pc_jump_D[32*i +: 32] : pc_branch_D[32*i +: 32];
      end
    if (stallF) begin
      m_red = 0;
      if (nr > 0 && nr >= m_prank) begin m_pend = 1; m_prank = nr; m_ptgt = nt; end
    end else if (m_pend) begin
      if (nr > m_prank) begin m_pc = nt; m_src = nr; end
      else begin m_pc = m_ptgt; m_src = m_prank; end
      m_red = 1; m_epoch = (m_epoch + 1) % 8; m_pend = 0; m_prank = 0;
    end else if (nr > 0) begin
      m_pc = nt; m_src = nr; m_red = 1; m_epoch = (m_epoch + 1) % 8;
    end else begin
      m_pc = m_pc + 32'd8; m_src = 0; m_red = 0;
    end
    e.pc = m_pc; e.src = m_src[1:0]; e.red = m_red; e.pend = m_pend; e.epoch = m_epoch[2:0];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    check_val("pc", pc, g.pc);
    check_val("src", {30'd0, redirect_src}, {30'd0, g.src});
    check_val("redirect", {31'd0, redirect}, {31'd0, g.red});
    check_val("pending", {31'd0, pending}, {31'd0, g.pend});
    check_val("epoch", {29'd0, epoch}, {29'd0, g.epoch});
    $display("[TB] t=%0t pc=%08h src=%0d red=%0b pend=%0b epoch=%0d", $time, pc,
             redirect_src, redirect, pending, epoch);
    clear_in();
  endtask

  initial begin
    int start_ep;
    z1 = 0; z32 = 0;
    rst = 0; rst1 = 0;
    clear_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_pc", pc, RPC);
    check_val("rst_red", {31'd0, redirect}, 32'd0);
    check_val("rst_src", {30'd0, redirect_src}, 32'd0);
    check_val("rst_pend", {31'd0, pending}, 32'd0);
    check_val("rst_epoch", {29'd0, epoch}, 32'd0);
    rst = 1; rst1 = 1;

    // 1: sequential fetch from reset vector.
    check_val("seq0", pc, 32'hbfc0_0000);
    step(); check_val("seq1", pc, 32'hbfc0_0008);
    step(); check_val("seq2", pc, 32'hbfc0_0010);
    check_val("lane1_seq", pc1, 32'hbfc0_0008);
    check_val("lane1_red", {31'd0, redirect1}, 32'd0);

    // 2: D jump on lane 1.
    jump_D = 2'b10; pc_jump_D[63:32] = 32'h8000_1000;
    step(); check_val("djump_pc", pc, 32'h8000_1000); check_val("djump_ep", {29'd0, epoch}, 32'd1);

    // 3: E mispredict (not-taken) overrides D.
    pred_take_E = 2'b01; actual_take_E = 2'b00; pc_plus8_E[31:0] = 32'h8000_0408;
    jump_D = 2'b01; pc_jump_D[31:0] = 32'h8000_5000;
    step(); check_val("emis_pc", pc, 32'h8000_0408); check_val("emis_src", {30'd0, redirect_src}, 32'd2);

    // 4: M trap on both lanes plus E mispredict; lane 0 wins.
    trap_M = 2'b11; pc_exc_M = {32'h8000_0180, 32'hbfc0_0380};
    pred_take_E = 2'b10; actual_take_E = 2'b00; pc_plus8_E[63:32] = 32'h8000_0abc;
    step(); check_val("trap_pc", pc, 32'hbfc0_0380); check_val("trap_src", {30'd0, redirect_src}, 32'd3);

    // 5: D then M while stalled; apply once on release.
    stallF = 1; jump_D = 2'b01; pc_jump_D[31:0] = 32'h8000_2000; step();
    stallF = 1; trap_M = 2'b01; pc_exc_M[31:0] = 32'hbfc0_0380; step();
    stallF = 1; step();
    step(); check_val("stall_pc", pc, 32'hbfc0_0380); check_val("stall_ep", {29'd0, epoch}, 32'd4);

    // Equal rank later overrides; lower rank later is ignored.
    stallF = 1; jump_D = 2'b01; pc_jump_D[31:0] = 32'h8000_3000; step();
    stallF = 1; pred_take_D = 2'b10; pc_branch_D[63:32] = 32'h8000_3100; step();
    step(); check_val("eq_override", pc, 32'h8000_3100);
    stallF = 1; pred_take_E = 2'b01; actual_take_E = 2'b01; step();  // no mispredict
    stallF = 1; pred_take_E = 2'b00; actual_take_E = 2'b01; pc_branch_E[31:0] = 32'h8000_4000; step();
    stallF = 1; jump_D = 2'b01; pc_jump_D[31:0] = 32'h8000_4400; step();
    step(); check_val("lower_ignored", pc, 32'h8000_4000);
    // Higher rank arriving on release beats the pending one.
    stallF = 1; jump_D = 2'b10; pc_jump_D[63:32] = 32'h8000_5500; step();
    trap_M = 2'b10; pc_exc_M[63:32] = 32'h8000_0180; step();
    check_val("release_higher", pc, 32'h8000_0180);
    step();

    // Epoch wrap: eight redirects bring the counter back around.
    start_ep = m_epoch;
    for (int k = 0; k < 8; k++) begin
      jump_D = 2'b01; pc_jump_D[31:0] = {$urandom} & 32'hffff_fffc; step();
    end
    check_val("epoch_wrap", {29'd0, epoch}, start_ep);

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      stallF = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 2; i++) begin
        trap_M[i]        = ($urandom_range(0, 15) == 0);
        pred_take_E[i]   = ($urandom_range(0, 7) == 0);
        actual_take_E[i] = ($urandom_range(0, 7) == 0);
        jump_D[i]        = ($urandom_range(0, 9) == 0);
        pred_take_D[i]   = ($urandom_range(0, 9) == 0);
      end
      pc_exc_M    = {$urandom, $urandom};
      pc_branch_E = {$urandom, $urandom};
      pc_plus8_E  = {$urandom, $urandom};
      pc_jump_D   = {$urandom, $urandom};
      pc_branch_D = {$urandom, $urandom};
      step();
    end

    // 6: reset during a stall with a pending D redirect.
    stallF = 1; jump_D = 2'b01; pc_jump_D[31:0] = 32'h8000_6000; step();
    stallF = 1; step();
    stallF = 1;
    #2 rst = 0;
    #1;
    model_reset();
    check_val("midrst_pc", pc, RPC);
    check_val("midrst_pend", {31'd0, pending}, 32'd0);
    check_val("midrst_epoch", {29'd0, epoch}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1;
    clear_in();
    step(); check_val("postrst_seq1", pc, 32'hbfc0_0008);
    step(); check_val("postrst_seq2", pc, 32'hbfc0_0010);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
